fe_fetch_sequencer: RTL and testbench
=====================================

// Module: fe_fetch_sequencer
// PURPOSE
//  Fetch-stage PC sequencer. Receives the branch-redirect bundle driven by AGEX (from_AGEX_to_FE)
//  and the stall from DE, drives the synchronous instruction memory, and fills FE_latch for DE.
//  A 1-entry hold buffer absorbs the in-flight imem response when DE stalls, so there is no refetch
//  and no lost instruction.
// PARAMETERS
//  DBITS     32       PC/data width
//  INSTBITS  32       instruction width
//  STARTPC   32'h200  PC of the first fetch after reset
// PORTS
//  clk               in   1                        clock, all state on posedge
//  reset             in   1                        synchronous, active-low (0 = reset)
//  from_AGEX_to_FE   in   1+DBITS                  {br_redirect_AGEX, pctarget_AGEX}
//  stall_DE          in   1                        DE cannot accept FE_latch this cycle
//  imem_addr         out  DBITS                    byte address of the current fetch request
//  imem_rdata        in   INSTBITS                 data for the previous cycle's imem_addr
//  FE_latch_out      out  1+INSTBITS+3*DBITS       {valid, inst, PC, pcplus, inst_count}
// BEHAVIOUR
//  - Regs: pc_f (next request), resp_pc/resp_v (request in flight), hold_inst/hold_pc,
//    FE_latch, inst_count. FSM: FETCH (hold empty), HOLD (hold full).
//  - imem_addr = pc_f (combinational from register). Data returns exactly 1 cycle later.
//  - Reset (reset==0 at posedge): pc_f=STARTPC, resp_v=0, FE_latch=0 (valid=0), inst_count=0,
//    state FETCH. Reset wins over everything. Reset mid-stall or mid-redirect discards all state.
//  - Per-cycle priority: reset > redirect > stall > normal.
//  - Redirect (br_redirect_AGEX=1): pc_f<=pctarget_AGEX with bits [1:0] forced to 00; resp_v<=0;
//    hold discarded -> FETCH; FE_latch.valid<=0. If FE_latch.valid was 1, inst_count<=inst_count-1.
//    stall_DE is ignored this cycle. No request is issued; the first target fetch is on the next cycle.
//  - Stall (stall_DE=1, no redirect): FE_latch holds. No request is issued (pc_f holds, resp_v<=0).
//    In FETCH with resp_v=1: hold<={imem_rdata, resp_pc}, go to HOLD. In HOLD: no change.
//  - Normal (stall_DE=0):
//      - Request: resp_pc<=pc_f, pc_f<=pc_f+4 (mod 2^DBITS), resp_v<=1.
//      - If HOLD: FE_latch<=hold entry, go to FETCH.
//      - Else if resp_v: FE_latch<=imem_rdata/resp_pc.
//      - Else FE_latch.valid<=0.
//  - Every valid load of FE_latch: inst_count<=inst_count+1; the latch carries the incremented value
//    (first instruction = 1). pcplus = PC+4 (mod 2^DBITS).
//  - Latency: first valid FE_latch 2 cycles after reset release; redirect-to-valid target
//    instruction = 3 cycles; steady state 1 instr/cycle; stall release gives back-to-back
//    hold -> fresh data with no bubble.
// CONFIGURATION
//  FE_PERF_CNT_EN defined: adds outputs perf_squash_cnt[31:0] (+1 per redirect that clears a valid
//    FE_latch or resp_v or hold entry; +1 per cycle, not per item) and perf_stall_cnt[31:0]
//    (+1 per cycle with stall_DE=1 and no redirect). Both counters are 0 at reset and saturate at
//    32'hFFFFFFFF.
//  FE_PERF_CNT_EN undefined: these ports and counters do not exist. All other behaviour is identical.
// TESTING
//  1. Release reset, no stall, imem[a]=a ->
//     imem_addr 200,204,208...; FE_latch valid from cycle 2: PC 200/inst 200/pcplus 204/count 1,
//     then 204/count 2.
//  2. stall_DE=1 for 3 cycles while PC 208 is in flight -> FE_latch holds 204 throughout;
//     imem_addr stays 20C; after release FE_latch = 208 then 20C, with no gap and no duplicate.
//  3. Redirect to 32'h403 while FE_latch valid (count 5) ->
//     next cycle valid=0, count 4, imem_addr=400; 2 cycles later FE_latch PC=400, count 5.
//  4. Redirect and stall_DE=1 in the same cycle while in HOLD -> hold discarded;
//     FE_latch.valid=0; fetch resumes at the target despite the stall.
//  5. pc_f=32'hFFFFFFFC -> next imem_addr=0; pcplus of FFFFFFFC=0.
//     reset=0 asserted during a stall -> all outputs are 0 next cycle and fetch restarts at 200.
//  6. With FE_PERF_CNT_EN: scenario 2 gives perf_stall_cnt=3; scenario 3 gives perf_squash_cnt=1.
//     Without the macro, the build elaborates with no perf ports.

Source files
------------

// File: rtl/fe_fetch_sequencer_if.sv
// rtl/fe_fetch_sequencer_if.sv - fetch-stage bundle: AGEX redirect, DE stall, imem port, FE_latch
interface fe_fetch_sequencer_if #(
  parameter int DBITS    = 32,
  parameter int INSTBITS = 32
);
  logic [DBITS:0]              from_AGEX_to_FE;
  logic                        stall_DE;
  logic [DBITS-1:0]            imem_addr;
  logic [INSTBITS-1:0]         imem_rdata;
  logic [INSTBITS+3*DBITS:0]   FE_latch_out;

  modport master (
    input  from_AGEX_to_FE,
    input  stall_DE,
    input  imem_rdata,
    output imem_addr,
    output FE_latch_out
  );

  modport slave (
    output from_AGEX_to_FE,
    output stall_DE,
    output imem_rdata,
    input  imem_addr,
    input  FE_latch_out
  );
endinterface

// File: rtl/fe_fetch_sequencer.sv
// rtl/fe_fetch_sequencer.sv - fetch PC sequencer with 1-entry hold buffer; FE_PERF_CNT_EN adds perf counters
module fe_fetch_sequencer #(
  parameter int               DBITS    = 32,
  parameter int               INSTBITS = 32,
  parameter logic [DBITS-1:0] STARTPC  = 32'h200
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef FE_PERF_CNT_EN
  output logic [31:0]              perf_squash_cnt,
  output logic [31:0]              perf_stall_cnt,
`endif
  fe_fetch_sequencer_if.master     fe
);

  typedef enum logic {S_FETCH, S_HOLD} state_t;

  state_t                state_q, state_d;
  logic [DBITS-1:0]      pc_q, pc_d;
  logic [DBITS-1:0]      resp_pc_q, resp_pc_d;
  logic                  resp_v_q, resp_v_d;
  logic [INSTBITS-1:0]   hold_inst_q, hold_inst_d;
  logic [DBITS-1:0]      hold_pc_q, hold_pc_d;
  logic                  lat_v_q, lat_v_d;
  logic [INSTBITS-1:0]   lat_inst_q, lat_inst_d;
  logic [DBITS-1:0]      lat_pc_q, lat_pc_d;
  logic [DBITS-1:0]      lat_pcplus_q, lat_pcplus_d;
  logic [DBITS-1:0]      cnt_q, cnt_d;

  logic                  redirect;
  logic [DBITS-1:0]      target;

  assign redirect = fe.from_AGEX_to_FE[DBITS];
  assign target   = fe.from_AGEX_to_FE[DBITS-1:0];

  assign fe.imem_addr    = pc_q;
  assign fe.FE_latch_out = {lat_v_q, lat_inst_q, lat_pc_q, lat_pcplus_q, cnt_q};

  // Next-state: redirect beats stall beats normal flow; the latch count field is the live counter
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    resp_pc_d    = resp_pc_q;
    resp_v_d     = resp_v_q;
    hold_inst_d  = hold_inst_q;
    hold_pc_d    = hold_pc_q;
    lat_v_d      = lat_v_q;
    lat_inst_d   = lat_inst_q;
    lat_pc_d     = lat_pc_q;
    lat_pcplus_d = lat_pcplus_q;
    cnt_d        = cnt_q;

    if (redirect) begin
      // Squash everything in flight; target fetch is issued next cycle
      pc_d     = {target[DBITS-1:2], 2'b00};
      resp_v_d = 1'b0;
      state_d  = S_FETCH;
      lat_v_d  = 1'b0;
      if (lat_v_q) begin
        cnt_d = cnt_q - DBITS'(1);
      end
    end else if (fe.stall_DE) begin
      // Park the in-flight response so it is neither lost nor refetched
      resp_v_d = 1'b0;
      if (state_q == S_FETCH && resp_v_q) begin
        hold_inst_d = fe.imem_rdata;
        hold_pc_d   = resp_pc_q;
        state_d     = S_HOLD;
      end
    end else begin
      resp_pc_d = pc_q;
      pc_d      = pc_q + DBITS'(4);
      resp_v_d  = 1'b1;
      if (state_q == S_HOLD) begin
        lat_v_d      = 1'b1;
        lat_inst_d   = hold_inst_q;
        lat_pc_d     = hold_pc_q;
        lat_pcplus_d = hold_pc_q + DBITS'(4);
        cnt_d        = cnt_q + DBITS'(1);
        state_d      = S_FETCH;
      end else if (resp_v_q) begin
        lat_v_d      = 1'b1;
        lat_inst_d   = fe.imem_rdata;
        lat_pc_d     = resp_pc_q;
        lat_pcplus_d = resp_pc_q + DBITS'(4);
        cnt_d        = cnt_q + DBITS'(1);
      end else begin
        lat_v_d = 1'b0;
      end
    end
  end

  // State registers; reset clears everything and restarts fetch at STARTPC
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      pc_q         <= STARTPC;
      resp_pc_q    <= '0;
      resp_v_q     <= 1'b0;
      hold_inst_q  <= '0;
      hold_pc_q    <= '0;
      lat_v_q      <= 1'b0;
      lat_inst_q   <= '0;
      lat_pc_q     <= '0;
      lat_pcplus_q <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      resp_pc_q    <= resp_pc_d;
      resp_v_q     <= resp_v_d;
      hold_inst_q  <= hold_inst_d;
      hold_pc_q    <= hold_pc_d;
      lat_v_q      <= lat_v_d;
      lat_inst_q   <= lat_inst_d;
      lat_pc_q     <= lat_pc_d;
      lat_pcplus_q <= lat_pcplus_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef FE_PERF_CNT_EN
  logic [31:0] squash_q, stall_q;
  logic        squash_hit;

  // A redirect counts once per cycle when it actually throws away a latch, response or hold entry
  assign squash_hit = redirect && (lat_v_q || resp_v_q || state_q == S_HOLD);

  assign perf_squash_cnt = squash_q;
  assign perf_stall_cnt  = stall_q;

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      squash_q <= '0;
      stall_q  <= '0;
    end else begin
      if (squash_hit && squash_q != 32'hFFFF_FFFF) begin
        squash_q <= squash_q + 32'd1;
      end
      if (fe.stall_DE && !redirect && stall_q != 32'hFFFF_FFFF) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fe_fetch_sequencer.sv
// tb/tb_fe_fetch_sequencer.sv - scoreboard bench for fe_fetch_sequencer (FE_PERF_CNT_EN optional)
module tb_fe_fetch_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fe_fetch_sequencer_if #(.DBITS(32), .INSTBITS(32)) fe ();

`ifdef FE_PERF_CNT_EN
  logic [31:0] perf_squash_cnt;
  logic [31:0] perf_stall_cnt;
  fe_fetch_sequencer #(.DBITS(32), .INSTBITS(32), .STARTPC(32'h200)) dut (
    .clk             (clk),
    .reset           (reset),
    .perf_squash_cnt (perf_squash_cnt),
    .perf_stall_cnt  (perf_stall_cnt),
    .fe              (fe)
  );
`else
  fe_fetch_sequencer #(.DBITS(32), .INSTBITS(32), .STARTPC(32'h200)) dut (
    .clk   (clk),
    .reset (reset),
    .fe    (fe)
  );
`endif

  logic        lv;
  logic [31:0] linst, lpc, lplus, lcnt;
  assign lv    = fe.FE_latch_out[128];
  assign linst = fe.FE_latch_out[127:96];
  assign lpc   = fe.FE_latch_out[95:64];
  assign lplus = fe.FE_latch_out[63:32];
  assign lcnt  = fe.FE_latch_out[31:0];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hCAFE_0000;
  endfunction

  // synchronous instruction memory model
  always @(posedge clk) fe.imem_rdata <= mem_word(fe.imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] cnt);
    exp_t e;
    e.pc  = pc;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic [31:0] tgt, input logic st);
    fe.from_AGEX_to_FE = {rd, tgt};
    fe.stall_DE        = st;
  endtask

  // Monitor: every new valid FE_latch load is popped against the scoreboard
  logic        prev_v = 1'b0;
  logic [31:0] prev_cnt = '0;
  always @(negedge clk) begin
    exp_t e;
    if (lv === 1'b1 && (!prev_v || lcnt !== prev_cnt)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon_unexpected actual_pc=%h actual_cnt=%0d required=none", lpc, lcnt);
      end else begin
        e = exp_q.pop_front();
        chk("mon_pc", lpc, e.pc);
        chk("mon_inst", linst, mem_word(e.pc));
        chk("mon_pcplus", lplus, e.pc + 32'd4);
        chk("mon_cnt", lcnt, e.cnt);
      end
    end
    prev_v   = lv;
    prev_cnt = lcnt;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 32'h0, 1'b0);
    reset = 1'b0;
    cyc();
    cyc();
    chk("rst_valid", {31'b0, lv}, 32'h0);
    chk("rst_latch_zero", {31'b0, |fe.FE_latch_out}, 32'h0);
    chk("rst_addr", fe.imem_addr, 32'h200);

    // streaming, then stall while 208 is in flight
    push(32'h200, 1); push(32'h204, 2); push(32'h208, 3); push(32'h20C, 4); push(32'h210, 5);
    reset = 1'b1;
    cyc();
    chk("s1_addr1", fe.imem_addr, 32'h204);
    chk("s1_valid1", {31'b0, lv}, 32'h0);
    cyc();
    chk("s1_addr2", fe.imem_addr, 32'h208);
    cyc();
    chk("s1_addr3", fe.imem_addr, 32'h20C);
    drive(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("s2_hold_pc", lpc, 32'h204);
      chk("s2_hold_valid", {31'b0, lv}, 32'h1);
      chk("s2_hold_addr", fe.imem_addr, 32'h20C);
    end
`ifdef FE_PERF_CNT_EN
    chk("perf_stall3", perf_stall_cnt, 32'd3);
`endif
    drive(1'b0, 32'h0, 1'b0);
    cyc();
    chk("s2_rel_pc", lpc, 32'h208);
    cyc();
    cyc();
    chk("s2_addr", fe.imem_addr, 32'h218);

    // redirect to unaligned 403 while latch valid with count 5
    push(32'h400, 5);
    drive(1'b1, 32'h403, 1'b0);
    cyc();
    chk("s3_valid", {31'b0, lv}, 32'h0);
    chk("s3_cnt", lcnt, 32'd4);
    chk("s3_addr", fe.imem_addr, 32'h400);
`ifdef FE_PERF_CNT_EN
    chk("perf_squash1", perf_squash_cnt, 32'd1);
`endif
    drive(1'b0, 32'h0, 1'b0);
    cyc();
    chk("s3_addr2", fe.imem_addr, 32'h404);
    cyc();
    chk("s3_tgt_pc", lpc, 32'h400);

    // redirect together with stall while HOLD is full
    push(32'h404, 6); push(32'h600, 6);
    cyc();
    drive(1'b0, 32'h0, 1'b1);
    cyc();
    chk("s4_stall_addr", fe.imem_addr, 32'h40C);
    drive(1'b1, 32'h600, 1'b1);
    cyc();
    chk("s4_valid", {31'b0, lv}, 32'h0);
    chk("s4_cnt", lcnt, 32'd5);
    chk("s4_addr", fe.imem_addr, 32'h600);
    drive(1'b0, 32'h0, 1'b0);
    cyc();
    chk("s4_addr2", fe.imem_addr, 32'h604);
    cyc();

    // PC wrap at top of address space
    push(32'hFFFF_FFFC, 6); push(32'h0, 7);
    drive(1'b1, 32'hFFFF_FFFE, 1'b0);
    cyc();
    chk("s5_addr_top", fe.imem_addr, 32'hFFFF_FFFC);
    drive(1'b0, 32'h0, 1'b0);
    cyc();
    chk("s5_addr_wrap", fe.imem_addr, 32'h0);
    cyc();
    chk("s5_pcplus_wrap", lplus, 32'h0);
    cyc();
    chk("s5_addr8", fe.imem_addr, 32'h8);

    // reset asserted during a stall
    push(32'h200, 1);
    drive(1'b0, 32'h0, 1'b1);
    cyc();
    reset = 1'b0;
    cyc();
    chk("s5_rst_latch_zero", {31'b0, |fe.FE_latch_out}, 32'h0);
    chk("s5_rst_addr", fe.imem_addr, 32'h200);
`ifdef FE_PERF_CNT_EN
    chk("perf_rst_squash", perf_squash_cnt, 32'd0);
    chk("perf_rst_stall", perf_stall_cnt, 32'd0);
`endif
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    cyc();
    chk("s5_restart_addr", fe.imem_addr, 32'h204);
    cyc();
    chk("s5_restart_cnt", lcnt, 32'd1);
    cyc();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
